mem_field_rmw: RTL

- Parametrised word memory with word-level and field-level (part-select) read and write access.
- Every write is read-modify-write, and a change-event pulse fires when a stored word actually changes value.
- A power-up clear sweep puts the array in a known state.
- Sits behind a valid/ready request port as the storage element for simulator regression designs and bus-attached register files.

---
 rtl/mem_field_rmw.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_field_rmw.sv
// Word memory with word and field read/write access. Every write is a read-modify-write,
// and chg pulses whenever a committed write actually alters the stored word.
module mem_field_rmw #(
  parameter int W     = 32,
  parameter int DEPTH = 1025,
  parameter int AW    = 11,
  parameter int FW    = 8,
  parameter int NF    = W / FW,
  parameter int FIW   = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [AW-1:0]  req_addr,
  input  logic [FIW-1:0] req_field,
  input  logic [W-1:0]   req_wdata,
  output logic           rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           chg,
  output logic [AW-1:0]  chg_addr,
  output logic           busy
);

  typedef enum logic [1:0] {CLEAR, IDLE, RMW} state_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [FIW:0]  NF_L    = (FIW+1)'(NF);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [W-1:0]   mem [DEPTH];
  state_t         state;
  logic [AW-1:0]  ptr;
  logic [AW-1:0]  pend_addr;
  logic [FIW-1:0] pend_field;
  logic           pend_field_op;
  logic           pend_err;
  logic [W-1:0]   pend_old;
  logic [W-1:0]   pend_wdata;

  logic           addr_ok;
  logic           req_ok;
  logic           accept;
  logic [W-1:0]   cur_word;
  logic [W-1:0]   cur_field;
  logic [W-1:0]   merged;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [W-1:0]   mem_wdata;

  // Request decode and combinational read of the addressed word
  always_comb begin
    addr_ok   = ({1'b0, req_addr} < DEPTH_L);
    req_ok    = addr_ok && (!req_op[1] || ({1'b0, req_field} < NF_L));
    accept    = req_valid && req_ready && (state == IDLE);
    cur_word  = addr_ok ? mem[req_addr] : '0;
    cur_field = '0;
    for (int k = 0; k < NF; k++) begin
      if (req_field == FIW'(k)) cur_field[FW-1:0] = cur_word[k*FW +: FW];
    end
  end

  // Merge of the pending write into the captured old word
  always_comb begin
    merged = pend_wdata;
    if (pend_field_op) begin
      merged = pend_old;
      for (int k = 0; k < NF; k++) begin
        if (pend_field == FIW'(k)) merged[k*FW +: FW] = pend_wdata[FW-1:0];
      end
    end
  end

  // Reset suppresses the write so an abandoned RMW never reaches the array
  always_comb begin
    mem_we    = !reset && ((state == CLEAR) || ((state == RMW) && !pend_err));
    mem_waddr = (state == CLEAR) ? ptr : pend_addr;
    mem_wdata = (state == CLEAR) ? '0 : merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      ptr           <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      chg           <= 1'b0;
      chg_addr      <= '0;
      busy          <= 1'b1;
      pend_addr     <= '0;
      pend_field    <= '0;
      pend_field_op <= 1'b0;
      pend_err      <= 1'b0;
      pend_old      <= '0;
      pend_wdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      chg       <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == LAST) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        IDLE: begin
          if (accept) begin
            if (!req_op[0]) begin
              rsp_valid <= 1'b1;
              rsp_err   <= !req_ok;
              rsp_data  <= !req_ok ? '0 : (req_op[1] ? cur_field : cur_word);
            end else begin
              // Rejected writes still take the RMW slot; the error is flagged right away
              pend_addr     <= req_addr;
              pend_field    <= req_field;
              pend_field_op <= req_op[1];
              pend_err      <= !req_ok;
              pend_old      <= cur_word;
              pend_wdata    <= req_wdata;
              rsp_err       <= !req_ok;
              req_ready     <= 1'b0;
              busy          <= 1'b1;
              state         <= RMW;
            end
          end
        end
        RMW: begin
          if (!pend_err && (merged != pend_old)) begin
            chg      <= 1'b1;
            chg_addr <= pend_addr;
          end
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule
